nvdla_rws_fifo_ctrl_128x18: RTL and testbench
=============================================

NVDLA_RWS_FIFO_CTRL_128X18 -- requirements
Module: nvdla_rws_fifo_ctrl_128x18

Interface
REQ-001 The block SHALL have no parameters; RAM depth 128 and width 18 are fixed.
REQ-002 nvdla_core_clk  input  1  sole clock; all state on its rising edge.
REQ-003 nvdla_core_rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 wr_pvld  input  1  push request.
REQ-005 wr_prdy  output  1  push accept; push occurs when wr_pvld & wr_prdy.
REQ-006 wr_pd  input  18  push data.
REQ-007 rd_pvld  output  1  pop data valid.
REQ-008 rd_prdy  input  1  pop accept; pop occurs when rd_pvld & rd_prdy.
REQ-009 rd_pd  output  18  pop data.
REQ-010 ram_we / ram_wa / ram_di  output  1/7/18  write port to external 128x18 RAM with registered read address.
REQ-011 ram_re / ram_ra  output  1/7  read port; RAM latches ram_ra on the edge where ram_re=1.
REQ-012 ram_dout  input  18  RAM data; valid in the cycle after a read issue.
REQ-013 fifo_cnt  output  8  total entries held (RAM + in-flight + output stage), 0..130.
REQ-014 pwrbus_ram_pd  input/output  32  passed combinationally to the RAM power-bus port.

Function
REQ-015 Capacity: 128 RAM entries plus a 2-entry output skid buffer; order strictly FIFO.
REQ-016 wr_ptr, rd_ptr are 7-bit and wrap 127->0; ram_cnt is 8-bit (0..128).
REQ-017 wr_prdy = (ram_cnt != 128), combinational, with no dependence on wr_pvld.
REQ-018 On push: ram_we=1, ram_wa=wr_ptr, ram_di=wr_pd in the same cycle; wr_ptr increments at the edge.
REQ-019 Read issue condition: ram_cnt != 0 and (out_cnt + inflight - pop_this_cycle) < 2.
REQ-020 On issue: ram_re=1, ram_ra=rd_ptr; rd_ptr increments, ram_cnt decrements, inflight is set to 1 for the next cycle.
REQ-021 When inflight=1, ram_dout SHALL be captured into the skid buffer at that cycle's closing edge; it SHALL NOT be sampled later.
REQ-022 ram_cnt next = ram_cnt + push - issue; simultaneous push and issue leaves it unchanged.
REQ-023 ram_re=0 and ram_we=0 whenever their conditions are false; ram_ra/ram_wa then hold pointer values.
REQ-024 Output stage: rd_pvld = (out_cnt != 0); rd_pd = head entry; pop advances the head.
REQ-025 Capture and pop may occur in the same cycle with no loss or duplication.
REQ-026 Push-to-rd_pvld latency on an empty FIFO SHALL be 3 cycles; sustained throughput SHALL be 1 push and 1 pop per cycle.
REQ-027 Overwrite safety: an address freed by issue in cycle N SHALL NOT be rewritten before the closing edge of cycle N+1, which is guaranteed by REQ-017 and REQ-020.
REQ-028 rd_pd SHALL hold stable while rd_pvld=1 and rd_prdy=0.
REQ-029 fifo_cnt = ram_cnt + inflight + out_cnt.

Reset
REQ-030 During reset, all of the following SHALL be 0: wr_ptr, rd_ptr, ram_cnt, inflight, out_cnt and the skid contents.
REQ-031 Reset output values SHALL be: wr_prdy=1, rd_pvld=0, rd_pd=0, ram_we=0, ram_re=0, ram_wa=0, ram_ra=0, ram_di=wr_pd, fifo_cnt=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately, with no RAM access in the reset cycle; RAM contents need not be cleared.

Verification
REQ-033 Single word: push 18'h2A5A5 into an empty FIFO -> ram_we with wa=0 in cycle 0, ram_re with ra=0 in cycle 1, rd_pvld=1 with rd_pd=18'h2A5A5 in cycle 3.
REQ-034 Fill: hold rd_prdy=0 and push 200 words -> 130 accepted, fifo_cnt=130, wr_prdy=0 once ram_cnt=128; then pop all -> values in order 0..129.
REQ-035 Wrap: stream 300 words with both sides always ready -> 1 word/cycle after the 3-cycle fill, data matches in order, pointers wrap twice.
REQ-036 Backpressure: toggle rd_prdy randomly 50% for 1000 words -> no loss or duplication, and rd_pd stable while stalled.
REQ-037 Full with simultaneous push/pop: with ram_cnt=128, pop one word -> an issue occurs, wr_prdy=1 next cycle, and a push to the freed address does not corrupt the captured word.
REQ-038 Reset mid-stream: assert nvdla_core_rstn=0 with fifo_cnt=50 -> fifo_cnt=0, rd_pvld=0, ram_re=0 immediately; after release, the first push is read back from address 0.

Source files
------------

// File: rtl/nvdla_rws_fifo_ctrl_128x18_if.sv
// Handshake, RAM-port and power-bus signals of the 128x18 RAM-backed FIFO
// controller. The controller attaches through the slave modport; the
// environment (producer, consumer and RAM) attaches through master.
interface nvdla_rws_fifo_ctrl_128x18_if;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [17:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [17:0] rd_pd;
  logic        ram_we;
  logic [6:0]  ram_wa;
  logic [17:0] ram_di;
  logic        ram_re;
  logic [6:0]  ram_ra;
  logic [17:0] ram_dout;
  logic [7:0]  fifo_cnt;
  logic [31:0] pwrbus_ram_pd;
  logic [31:0] ram_pwrbus_pd;

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd,
    output wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di,
           ram_re, ram_ra, fifo_cnt, ram_pwrbus_pd
  );

  modport master (
    output wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd,
    input  wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di,
           ram_re, ram_ra, fifo_cnt, ram_pwrbus_pd
  );
endinterface

// File: rtl/nvdla_rws_fifo_ctrl_128x18.sv
// FIFO controller for an external 128x18 RAM with a registered read address.
// Entries are written straight into the RAM; reads are issued ahead so that a
// two-entry skid buffer in front of the consumer stays full. Total capacity is
// 130 entries and ordering is strictly first-in first-out.
module nvdla_rws_fifo_ctrl_128x18 (
  input logic                         nvdla_core_clk,
  input logic                         nvdla_core_rstn,
  nvdla_rws_fifo_ctrl_128x18_if.slave fifo
);
  localparam logic [7:0] RAM_DEPTH = 8'd128;

  logic [6:0]  wr_ptr;
  logic [6:0]  rd_ptr;
  logic [7:0]  ram_cnt;
  logic        inflight;
  logic [1:0]  out_cnt;
  logic [17:0] skid_head;
  logic [17:0] skid_next;

  logic        push;
  logic        pop;
  logic        issue;
  logic [2:0]  out_pending;

  // Handshakes and read-ahead decision: issue only while the skid buffer
  // (counting the word already in flight and this cycle's pop) has room.
  always_comb begin
    fifo.wr_prdy = (ram_cnt != RAM_DEPTH);
    push         = fifo.wr_pvld & fifo.wr_prdy;
    pop          = fifo.rd_pvld & fifo.rd_prdy;
    out_pending  = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, pop};
    issue        = (ram_cnt != 8'd0) && (out_pending < 3'd2);
  end

  // RAM ports follow the pointers; the write strobe is held off while reset
  // is asserted so that a mid-operation reset produces no RAM access.
  assign fifo.ram_we        = push & nvdla_core_rstn;
  assign fifo.ram_wa        = wr_ptr;
  assign fifo.ram_di        = fifo.wr_pd;
  assign fifo.ram_re        = issue;
  assign fifo.ram_ra        = rd_ptr;
  assign fifo.rd_pvld       = (out_cnt != 2'd0);
  assign fifo.rd_pd         = skid_head;
  assign fifo.fifo_cnt      = ram_cnt + {7'd0, inflight} + {6'd0, out_cnt};
  assign fifo.ram_pwrbus_pd = fifo.pwrbus_ram_pd;

  // RAM-side bookkeeping: pointers, occupancy and the one-cycle read flag.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr   <= 7'd0;
      rd_ptr   <= 7'd0;
      ram_cnt  <= 8'd0;
      inflight <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 7'd1;
      if (issue) rd_ptr <= rd_ptr + 7'd1;
      ram_cnt  <= ram_cnt + {7'd0, push} - {7'd0, issue};
      inflight <= issue;
    end
  end

  // Skid buffer: capture RAM data exactly in the cycle after issue, shift the
  // head out on pop; capture and pop together keep the count unchanged.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_cnt   <= 2'd0;
      skid_head <= 18'd0;
      skid_next <= 18'd0;
    end else begin
      case ({inflight, pop})
        2'b01: begin
          skid_head <= skid_next;
          out_cnt   <= out_cnt - 2'd1;
        end
        2'b10: begin
          if (out_cnt == 2'd0) skid_head <= fifo.ram_dout;
          else                 skid_next <= fifo.ram_dout;
          out_cnt <= out_cnt + 2'd1;
        end
        2'b11: begin
          if (out_cnt == 2'd1) begin
            skid_head <= fifo.ram_dout;
          end else begin
            skid_head <= skid_next;
            skid_next <= fifo.ram_dout;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nvdla_rws_fifo_ctrl_128x18.sv
// Bench for the 128x18 RAM-backed FIFO controller: a 128x18 RAM model with a
// registered read address, directed scenarios with literal expectations, and
// a queue-based reference checked on every falling clock edge.
`timescale 1ns/1ps
module tb_nvdla_rws_fifo_ctrl_128x18;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nvdla_rws_fifo_ctrl_128x18_if bus();

  nvdla_rws_fifo_ctrl_128x18 dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .fifo            (bus)
  );

  // RAM model: data is only valid in the cycle after a read; otherwise junk.
  logic [17:0] mem [0:127];
  logic        re_q;
  logic [6:0]  ra_q;
  logic [17:0] junk;
  always_ff @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_wa] <= bus.ram_di;
    re_q <= bus.ram_re;
    ra_q <= bus.ram_ra;
    junk <= 18'($urandom);
  end
  assign bus.ram_dout = re_q ? mem[ra_q] : junk;

  typedef struct {
    logic [17:0] data;
    int unsigned cyc;
  } ent_t;

  ent_t        q[$];
  int unsigned cyc_n  = 0;
  int unsigned pushes = 0;
  int unsigned issued = 0;
  int          n_vec  = 0;
  int          n_err  = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_pd    = 18'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.pwrbus_ram_pd = $urandom;
  endtask

  // Reference model: the FIFO holds an ordered list of accepted words; a word
  // is presented 3 cycles after its push once it has reached the head.
  initial begin
    logic exp_vld;
    forever begin
      @(negedge clk);
      cyc_n++;
      chk("pwrbus", bus.ram_pwrbus_pd, bus.pwrbus_ram_pd);
      if (!rstn) begin
        chk("rst_wr_prdy", 32'(bus.wr_prdy), 1);
        chk("rst_rd_pvld", 32'(bus.rd_pvld), 0);
        chk("rst_rd_pd",   32'(bus.rd_pd), 0);
        chk("rst_ram_we",  32'(bus.ram_we), 0);
        chk("rst_ram_re",  32'(bus.ram_re), 0);
        chk("rst_ram_wa",  32'(bus.ram_wa), 0);
        chk("rst_ram_ra",  32'(bus.ram_ra), 0);
        chk("rst_ram_di",  32'(bus.ram_di), 32'(bus.wr_pd));
        chk("rst_fifo_cnt", 32'(bus.fifo_cnt), 0);
        q.delete();
        pushes     = 0;
        issued     = 0;
        prev_stall = 1'b0;
      end else begin
        exp_vld = (q.size() != 0) && (q[0].cyc + 3 <= cyc_n);
        chk("rd_pvld", 32'(bus.rd_pvld), 32'(exp_vld));
        if (bus.rd_pvld && q.size() != 0) chk("rd_pd", 32'(bus.rd_pd), 32'(q[0].data));
        if (prev_stall) chk("stall_rd_pd", 32'(bus.rd_pd), 32'(prev_pd));
        chk("fifo_cnt", 32'(bus.fifo_cnt), 32'(q.size()));
        if (q.size() < 128)       chk("wr_prdy_room", 32'(bus.wr_prdy), 1);
        else if (q.size() == 130) chk("wr_prdy_full", 32'(bus.wr_prdy), 0);
        chk("ram_we", 32'(bus.ram_we), 32'(bus.wr_pvld & bus.wr_prdy));
        chk("ram_wa", 32'(bus.ram_wa), pushes % 128);
        chk("ram_di", 32'(bus.ram_di), 32'(bus.wr_pd));
        if (bus.ram_re) begin
          chk("ram_ra", 32'(bus.ram_ra), issued % 128);
          chk("issue_has_word", 32'(issued < pushes), 1);
          issued++;
        end
        if (bus.rd_pvld && bus.rd_prdy && q.size() != 0) void'(q.pop_front());
        if (bus.wr_pvld && bus.wr_prdy) begin
          q.push_back('{data: bus.wr_pd, cyc: cyc_n});
          pushes++;
        end
        prev_stall = bus.rd_pvld & ~bus.rd_prdy;
        prev_pd    = bus.rd_pd;
      end
    end
  end

  initial begin
    int nacc;
    int expv;
    int sent;
    int popc;
    logic done;
    bus.wr_pvld       = 1'b1;
    bus.wr_pd         = 18'h15555;
    bus.rd_prdy       = 1'b0;
    bus.pwrbus_ram_pd = 32'hA5A5_0F0F;
    repeat (3) step();
    rstn        = 1'b1;
    bus.wr_pvld = 1'b0;

    // Single word through an empty FIFO.
    step();
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 18'h2A5A5;
    @(negedge clk);
    chk("w1_ram_we", 32'(bus.ram_we), 1);
    chk("w1_ram_wa", 32'(bus.ram_wa), 0);
    step();
    bus.wr_pvld = 1'b0;
    @(negedge clk);
    chk("w1_ram_re", 32'(bus.ram_re), 1);
    chk("w1_ram_ra", 32'(bus.ram_ra), 0);
    step();
    @(negedge clk);
    chk("w1_early_vld", 32'(bus.rd_pvld), 0);
    step();
    @(negedge clk);
    chk("w1_rd_pvld", 32'(bus.rd_pvld), 1);
    chk("w1_rd_pd", 32'(bus.rd_pd), 32'h2A5A5);
    step();
    bus.rd_prdy = 1'b1;
    step();
    bus.rd_prdy = 1'b0;

    // Fill with the consumer stalled.
    nacc = 0;
    repeat (200) begin
      bus.wr_pvld = 1'b1;
      bus.wr_pd   = 18'(nacc);
      @(negedge clk);
      if (bus.wr_prdy) nacc++;
      step();
    end
    bus.wr_pvld = 1'b0;
    @(negedge clk);
    chk("fill_accepted", 32'(nacc), 130);
    chk("fill_cnt", 32'(bus.fifo_cnt), 130);
    chk("fill_wr_prdy", 32'(bus.wr_prdy), 0);

    // Pop one from full: read issue in the same cycle, room the next.
    step();
    bus.rd_prdy = 1'b1;
    @(negedge clk);
    chk("full_pop_re", 32'(bus.ram_re), 1);
    chk("full_pop_pd", 32'(bus.rd_pd), 0);
    step();
    bus.rd_prdy = 1'b0;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 18'd130;
    @(negedge clk);
    chk("freed_wr_prdy", 32'(bus.wr_prdy), 1);
    step();
    bus.wr_pvld = 1'b0;
    bus.rd_prdy = 1'b1;
    expv = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.rd_pvld) begin
        chk("drain_order", 32'(bus.rd_pd), 32'(expv));
        expv++;
      end
      if (expv == 131) break;
      step();
    end
    chk("drain_count", 32'(expv), 131);
    step();
    bus.rd_prdy = 1'b0;

    // Streaming with both sides ready: one word per cycle after 3-cycle fill.
    bus.wr_pvld = 1'b1;
    bus.rd_prdy = 1'b1;
    sent = 0;
    popc = 0;
    for (int c = 0; c < 303; c++) begin
      bus.wr_pd = 18'($urandom);
      if (sent == 300) bus.wr_pvld = 1'b0;
      @(negedge clk);
      if (bus.wr_pvld && bus.wr_prdy) sent++;
      if (bus.rd_pvld) popc++;
      step();
    end
    chk("stream_sent", 32'(sent), 300);
    chk("stream_pops", 32'(popc), 300);
    bus.wr_pvld = 1'b0;
    bus.rd_prdy = 1'b0;

    // Random backpressure on both sides.
    sent = 0;
    done = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      bus.wr_pvld = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus.wr_pd   = 18'($urandom);
      bus.rd_prdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.wr_pvld && bus.wr_prdy) sent++;
      if (sent == 1000 && bus.fifo_cnt == 8'd0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("bp_sent", 32'(sent), 1000);
    chk("bp_drained", 32'(done), 1);
    step();
    bus.wr_pvld = 1'b0;
    bus.rd_prdy = 1'b0;

    // Reset in the middle of a stream holding 50 words.
    for (int c = 0; c < 50; c++) begin
      bus.wr_pvld = 1'b1;
      bus.wr_pd   = 18'($urandom);
      step();
    end
    bus.wr_pvld = 1'b0;
    @(negedge clk);
    chk("pre_rst_cnt", 32'(bus.fifo_cnt), 50);
    step();
    bus.rd_prdy = 1'b1;
    #1;
    chk("pre_rst_re", 32'(bus.ram_re), 1);
    rstn        = 1'b0;
    bus.wr_pvld = 1'b1;
    #1;
    chk("rst_now_cnt", 32'(bus.fifo_cnt), 0);
    chk("rst_now_vld", 32'(bus.rd_pvld), 0);
    chk("rst_now_re", 32'(bus.ram_re), 0);
    chk("rst_now_we", 32'(bus.ram_we), 0);
    repeat (2) step();
    rstn        = 1'b1;
    bus.wr_pvld = 1'b0;
    bus.rd_prdy = 1'b0;
    step();
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 18'h3C0F1;
    @(negedge clk);
    chk("post_rst_wa", 32'(bus.ram_wa), 0);
    chk("post_rst_we", 32'(bus.ram_we), 1);
    step();
    bus.wr_pvld = 1'b0;
    @(negedge clk);
    chk("post_rst_re", 32'(bus.ram_re), 1);
    chk("post_rst_ra", 32'(bus.ram_ra), 0);
    step();
    step();
    @(negedge clk);
    chk("post_rst_vld", 32'(bus.rd_pvld), 1);
    chk("post_rst_pd", 32'(bus.rd_pd), 32'h3C0F1);
    step();
    bus.rd_prdy = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
